// File: rtl/fruit_sprite_arbiter.sv
// fruit_sprite_arbiter
// Shares one 50x50 sprite image/palette ROM pair between several fruit objects.
// On every pixel it picks the lowest-index enabled sprite that covers (x,y),
// issues the ROM address and fruit select, carries hit/valid tags alongside the
// ROM read latency, and applies colour-key transparency at the output.
// Sprite positions and enables are held in shadow registers that are reloaded
// only on frame_start, so an object never tears mid-frame.
// Optional build macro: FRUIT_SPRITE_OVERLAP_EN adds sticky per-sprite
// overlap_flags for blade/fruit collision logic.

module fruit_sprite_arbiter #(
    parameter int          NUM_SPRITES       = 4,
    parameter int          SPRITE_W          = 50,
    parameter int          SPRITE_H          = 50,
    parameter int          ROM_LATENCY       = 2,
    parameter logic [11:0] TRANSPARENT_COLOR = 12'h0F0,
    parameter int          ADDR_W            = $clog2(SPRITE_W * SPRITE_H) + 1,
    localparam int         SEL_W             = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [9:0]                x,
    input  logic [8:0]                y,
    input  logic                      pix_valid,
    input  logic                      frame_start,
    input  logic [10*NUM_SPRITES-1:0] sprite_x,
    input  logic [9*NUM_SPRITES-1:0]  sprite_y,
    input  logic [NUM_SPRITES-1:0]    sprite_en,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic [SEL_W-1:0]          rom_sel,
    input  logic [11:0]               rom_data,
    output logic [11:0]               pix_out,
    output logic                      pix_hit,
`ifdef FRUIT_SPRITE_OVERLAP_EN
    output logic [NUM_SPRITES-1:0]    overlap_flags,
`endif
    output logic                      pix_out_valid
);

    // ------------------------------------------------------------------
    // Shadow copies of the per-frame sprite placement
    // ------------------------------------------------------------------
    logic [9:0]             r_sx [NUM_SPRITES];
    logic [8:0]             r_sy [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_en;

    // Reload shadows at the start of vertical blank; hold them otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: these per-sprite arrays are a handful of flops, not a RAM,
            // so they are reset; clearing r_en is what keeps sprites hidden
            // until the first frame_start.
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
            end
            r_en <= '0;
        end else if (frame_start) begin
            // NOTE: non-blocking assignment, so a pixel in this same cycle
            // still sees the old placement.
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sx[i] <= sprite_x[10*i +: 10];
                r_sy[i] <= sprite_y[9*i +: 9];
            end
            r_en <= sprite_en;
        end
    end

    // ------------------------------------------------------------------
    // Coverage test and priority select
    // ------------------------------------------------------------------
    logic [NUM_SPRITES-1:0] w_cover;
    logic                   w_any;
    logic [SEL_W-1:0]       w_sel;
    logic [9:0]             w_dx;
    logic [8:0]             w_dy;
    logic [ADDR_W-1:0]      w_addr;

    // Per-sprite bounding-box test in widened arithmetic so boxes that run
    // past the right/bottom screen edge never wrap back to small coordinates.
    always_comb begin
        // NOTE: default first so every path assigns w_cover and no latch forms.
        w_cover = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_cover[i] = r_en[i]
                && ({1'b0, x} >= {1'b0, r_sx[i]})
                && ({1'b0, x} <  ({1'b0, r_sx[i]} + 11'(SPRITE_W)))
                && ({1'b0, y} >= {1'b0, r_sy[i]})
                && ({1'b0, y} <  ({1'b0, r_sy[i]} + 10'(SPRITE_H)));
        end
    end

    // Lowest index wins: scan downward so the last match written is index 0.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_cover[i]) begin
                w_sel = SEL_W'(i);
            end
        end
    end

    assign w_any = |w_cover;

    // Sprite-local offset of the pixel and the row-major ROM address.
    always_comb begin
        w_dx   = x - r_sx[w_sel];
        w_dy   = y - r_sy[w_sel];
        w_addr = ADDR_W'(w_dx) + ADDR_W'(SPRITE_W) * ADDR_W'(w_dy);
        if (!w_any) begin
            w_addr = '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: ROM request plus hit/valid tags
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_rom_addr;
    logic [SEL_W-1:0]  r_rom_sel;
    logic              r_hit1;
    logic              r_v1;

    // Register the ROM address/select and the tags for the issued pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr <= '0;
            r_rom_sel  <= '0;
            r_hit1     <= 1'b0;
            r_v1       <= 1'b0;
        end else begin
            r_rom_addr <= w_addr;
            r_rom_sel  <= w_sel;
            r_hit1     <= pix_valid && w_any;
            r_v1       <= pix_valid;
        end
    end

    assign rom_addr = r_rom_addr;
    assign rom_sel  = r_rom_sel;

    // ------------------------------------------------------------------
    // Tag delay line matching the ROM read latency
    // ------------------------------------------------------------------
    logic [ROM_LATENCY-1:0] r_hit_pipe;
    logic [ROM_LATENCY-1:0] r_v_pipe;

    // Shift tags every cycle; the pipeline never stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_pipe <= '0;
            r_v_pipe   <= '0;
        end else begin
            r_hit_pipe[0] <= r_hit1;
            r_v_pipe[0]   <= r_v1;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_hit_pipe[i] <= r_hit_pipe[i-1];
                r_v_pipe[i]   <= r_v_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output: colour-key transparency on the returning ROM data
    // ------------------------------------------------------------------
    logic w_hit_d;
    logic w_v_d;

    assign w_hit_d       = r_hit_pipe[ROM_LATENCY-1];
    assign w_v_d         = r_v_pipe[ROM_LATENCY-1];
    assign pix_out_valid = w_v_d;
    assign pix_hit       = w_hit_d && (rom_data != TRANSPARENT_COLOR);
    assign pix_out       = pix_hit ? rom_data : 12'h000;

`ifdef FRUIT_SPRITE_OVERLAP_EN
    // ------------------------------------------------------------------
    // Sticky overlap flags for collision logic
    // ------------------------------------------------------------------
    logic                   w_multi;
    logic [NUM_SPRITES-1:0] r_overlap;

    // Two or more sprites cover this pixel when clearing the lowest set
    // cover bit still leaves something behind.
    assign w_multi = |(w_cover & (w_cover - NUM_SPRITES'(1)));

    // Clear on frame_start, but a set in the same cycle takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overlap <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (pix_valid && w_multi && w_cover[i]) begin
                    r_overlap[i] <= 1'b1;
                end else if (frame_start) begin
                    r_overlap[i] <= 1'b0;
                end
            end
        end
    end

    assign overlap_flags = r_overlap;
`endif

endmodule

// File: tb/tb_fruit_sprite_arbiter.sv
// tb_fruit_sprite_arbiter
// Directed bench for fruit_sprite_arbiter. A two-cycle behavioural ROM returns
// a colour derived from (rom_addr, rom_sel), with address 5 returning the
// transparent colour. Expected values are hand-computed constants.

module tb_fruit_sprite_arbiter;

    logic        clk;
    logic        reset_n;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        pix_valid;
    logic        frame_start;
    logic [39:0] sprite_x;
    logic [35:0] sprite_y;
    logic [3:0]  sprite_en;
    logic [12:0] rom_addr;
    logic [1:0]  rom_sel;
    logic [11:0] rom_data;
    logic [11:0] pix_out;
    logic        pix_hit;
    logic        pix_out_valid;
`ifdef FRUIT_SPRITE_OVERLAP_EN
    logic [3:0]  overlap_flags;
`endif

    int checks = 0;
    int errors = 0;

    fruit_sprite_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .x             (x),
        .y             (y),
        .pix_valid     (pix_valid),
        .frame_start   (frame_start),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_en     (sprite_en),
        .rom_addr      (rom_addr),
        .rom_sel       (rom_sel),
        .rom_data      (rom_data),
        .pix_out       (pix_out),
        .pix_hit       (pix_hit),
`ifdef FRUIT_SPRITE_OVERLAP_EN
        .overlap_flags (overlap_flags),
`endif
        .pix_out_valid (pix_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ROM: address 5 is transparent, everything else has bit 11
    // set so it can never equal the colour key.
    function automatic logic [11:0] rom_f(input logic [12:0] a, input logic [1:0] s);
        if (a == 13'd5) return 12'h0F0;
        return {1'b1, s[0], a[9:0]};
    endfunction

    logic [11:0] rom_d1;
    always @(posedge clk) begin
        rom_d1   <= rom_f(rom_addr, rom_sel);
        rom_data <= rom_d1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int px, input int py, input logic v);
        x         = 10'(px);
        y         = 9'(py);
        pix_valid = v;
    endtask

    initial begin
        reset_n     = 1'b0;
        x           = '0;
        y           = '0;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        sprite_x    = '0;
        sprite_y    = '0;
        sprite_en   = '0;
        #1;
        check("rst_addr",  32'(rom_addr), 32'd0);
        check("rst_sel",   32'(rom_sel), 32'd0);
        check("rst_pout",  32'(pix_out), 32'd0);
        check("rst_hit",   32'(pix_hit), 32'd0);
        check("rst_valid", 32'(pix_out_valid), 32'd0);
`ifdef FRUIT_SPRITE_OVERLAP_EN
        check("rst_ovl", 32'(overlap_flags), 32'd0);
`endif
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Sprite 0 at (100,200)
        sprite_x[9:0] = 10'd100;
        sprite_y[8:0] = 9'd200;
        sprite_en     = 4'b0001;
        frame_start   = 1'b1;
        tick();
        frame_start = 1'b0;

        pixel(100, 200, 1'b1);
        tick();
        check("s0_tl_addr", 32'(rom_addr), 32'd0);
        check("s0_tl_sel",  32'(rom_sel), 32'd0);
        pixel(149, 249, 1'b1);
        tick();
        check("s0_br_addr", 32'(rom_addr), 32'd2499);
        pixel(150, 200, 1'b1);
        tick();
        check("s0_out_addr", 32'(rom_addr), 32'd0);
        check("s0_tl_valid", 32'(pix_out_valid), 32'd1);
        check("s0_tl_hit",   32'(pix_hit), 32'd1);
        check("s0_tl_pix",   32'(pix_out), 32'h800);
        pixel(105, 200, 1'b1);
        tick();
        check("s0_tr_addr",  32'(rom_addr), 32'd5);
        check("s0_br_hit",   32'(pix_hit), 32'd1);
        check("s0_br_pix",   32'(pix_out), 32'h9C3);
        pixel(0, 0, 1'b0);
        tick();
        check("s0_out_valid", 32'(pix_out_valid), 32'd1);
        check("s0_out_hit",   32'(pix_hit), 32'd0);
        check("s0_out_pix",   32'(pix_out), 32'h000);
        tick();
        check("s0_tr_valid", 32'(pix_out_valid), 32'd1);
        check("s0_tr_hit",   32'(pix_hit), 32'd0);
        check("s0_tr_pix",   32'(pix_out), 32'h000);
        tick();
        check("idle_valid", 32'(pix_out_valid), 32'd0);

        // Sprites 1 and 2 stacked at (300,100); lower index wins
        sprite_x        = '0;
        sprite_y        = '0;
        sprite_x[19:10] = 10'd300;
        sprite_x[29:20] = 10'd300;
        sprite_y[17:9]  = 9'd100;
        sprite_y[26:18] = 9'd100;
        sprite_en       = 4'b0110;
        frame_start     = 1'b1;
        tick();
        frame_start = 1'b0;
        pixel(310, 105, 1'b1);
        tick();
        check("pri_addr", 32'(rom_addr), 32'd260);
        check("pri_sel",  32'(rom_sel), 32'd1);
        pixel(0, 0, 1'b0);
        tick();
        tick();
        check("pri_hit", 32'(pix_hit), 32'd1);
        check("pri_pix", 32'(pix_out), 32'hD04);
`ifdef FRUIT_SPRITE_OVERLAP_EN
        check("ovl_set", 32'(overlap_flags), 32'b0110);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("ovl_clr", 32'(overlap_flags), 32'd0);
`endif

        // Sprite 0 at (620,470) hangs off the bottom-right corner
        sprite_x      = '0;
        sprite_y      = '0;
        sprite_x[9:0] = 10'd620;
        sprite_y[8:0] = 9'd470;
        sprite_en     = 4'b0001;
        frame_start   = 1'b1;
        tick();
        frame_start = 1'b0;
        pixel(639, 479, 1'b1);
        tick();
        check("edge_addr", 32'(rom_addr), 32'd469);
        check("edge_sel",  32'(rom_sel), 32'd0);
        pixel(5, 2, 1'b1);
        tick();
        check("nowrap_addr", 32'(rom_addr), 32'd0);
        pixel(0, 0, 1'b0);
        tick();
        check("edge_hit", 32'(pix_hit), 32'd1);
        check("edge_pix", 32'(pix_out), 32'h9D5);
        tick();
        check("nowrap_valid", 32'(pix_out_valid), 32'd1);
        check("nowrap_hit",   32'(pix_hit), 32'd0);

        // Move sprite 0 to (0,0) without frame_start: old placement persists
        sprite_x[9:0] = 10'd0;
        sprite_y[8:0] = 9'd0;
        pixel(625, 475, 1'b1);
        tick();
        check("hold_addr", 32'(rom_addr), 32'd255);
        pixel(10, 10, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_same_addr", 32'(rom_addr), 32'd0);
        pixel(10, 10, 1'b1);
        tick();
        check("fs_next_addr", 32'(rom_addr), 32'd510);
        check("hold_pix",     32'(pix_out), 32'h8FF);
        tick();
        check("fs_same_valid", 32'(pix_out_valid), 32'd1);
        check("fs_same_hit",   32'(pix_hit), 32'd0);
        tick();
        check("fs_next_hit", 32'(pix_hit), 32'd1);
        check("fs_next_pix", 32'(pix_out), 32'h9FE);

        // Reset with the pipeline full of hits
        reset_n = 1'b0;
        #1;
        check("mrst_valid", 32'(pix_out_valid), 32'd0);
        check("mrst_hit",   32'(pix_hit), 32'd0);
        check("mrst_pix",   32'(pix_out), 32'd0);
        check("mrst_addr",  32'(rom_addr), 32'd0);
        tick();
        reset_n   = 1'b1;
        sprite_en = 4'hF;
        pixel(10, 10, 1'b1);
        tick();
        check("post_addr", 32'(rom_addr), 32'd0);
        tick();
        tick();
        check("post_valid", 32'(pix_out_valid), 32'd1);
        check("post_hit",   32'(pix_hit), 32'd0);
        check("post_pix",   32'(pix_out), 32'd0);
`ifdef FRUIT_SPRITE_OVERLAP_EN
        check("post_ovl", 32'(overlap_flags), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fruit_sprite_arbiter.md
Name: fruit_sprite_arbiter

Overview:
- Shares one sprite image/palette ROM pair, 50x50 with 2-cycle read latency, between NUM_SPRITES on-screen fruit objects.
- Each VGA pixel: selects the highest-priority enabled sprite covering (x,y), generates the ROM address, and pipelines hit/select tags to line up with ROM data.
- Applies transparency and emits a final fruit pixel plus hit flag to the VGA compositor.
- Sprite coordinates are double-buffered per frame so objects never tear mid-frame.

Parameters:
- NUM_SPRITES, 4, number of fruit objects arbitrated.
- SPRITE_W, 50, sprite width in pixels.
- SPRITE_H, 50, sprite height in pixels.
- ROM_LATENCY, 2, cycles from rom_addr to valid rom_data (image RAM plus palette RAM).
- TRANSPARENT_COLOR, 12'h0F0, palette colour treated as "no fruit".
- ADDR_W, $clog2(SPRITE_W*SPRITE_H)+1, ROM address width (13 at defaults).

Ports:
- clk  in  1  pixel-domain clock.
- reset_n  in  1  asynchronous active-low reset.
- x  in  10  current pixel column.
- y  in  9  current pixel row.
- pix_valid  in  1  x,y is a visible pixel this cycle.
- frame_start  in  1  one-cycle pulse at start of vertical blank; latches coordinates.
- sprite_x  in  10*NUM_SPRITES  top-left columns, sprite i at [10i+9:10i].
- sprite_y  in  9*NUM_SPRITES  top-left rows, sprite i at [9i+8:9i].
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- rom_addr  out  ADDR_W  address to shared sprite image ROM.
- rom_sel  out  $clog2(NUM_SPRITES)  sprite index driving the ROM fruit-image mux.
- rom_data  in  12  palette colour, ROM_LATENCY cycles after rom_addr.
- pix_out  out  12  fruit colour for the compositor.
- pix_hit  out  1  pix_out is an opaque fruit pixel.
- pix_out_valid  out  1  pix_out/pix_hit correspond to a pixel issued 1+ROM_LATENCY cycles earlier.

Behaviour:
- Reset (async assert, sync deassert):
  - Clears all shadow registers, including shadow enables, so no sprite is active.
  - rom_addr=0, rom_sel=0, pix_out=0, pix_hit=0, pix_out_valid=0; tag pipeline cleared.
- Shadow latch: on frame_start, copy sprite_x, sprite_y and sprite_en into shadow registers.
  - A pixel presented in the same cycle as frame_start uses the old shadow values; new values apply from the next cycle.
  - After reset, no sprite appears until the first frame_start.
- Coverage for sprite i: en_i && x>=sx_i && x<sx_i+SPRITE_W && y>=sy_i && y<sy_i+SPRITE_H.
  - Compare in 11/10-bit widened arithmetic; sprites extending past x=639 or y=479 never wrap.
- Priority: lowest index wins among covering sprites.
- Stage 1 (registered, 1 cycle):
  - rom_addr = (x-sx_w) + SPRITE_W*(y-sy_w), truncated to ADDR_W; rom_sel = w.
  - Tag hit1 = pix_valid && any covering; tag v1 = pix_valid.
  - With no covering sprite: rom_addr=0, rom_sel=0, hit1=0.
- Tag pipeline: hit1/v1 delayed ROM_LATENCY further cycles. Total latency x,y -> pix_out = 1+ROM_LATENCY (3 at defaults).
- Output stage, combinational on delayed tags and rom_data, registered in tag stages only:
  - pix_out_valid = v_d.
  - pix_hit = hit_d && (rom_data != TRANSPARENT_COLOR).
  - pix_out = pix_hit ? rom_data : 12'h000.
- pix_valid=0: stage-1 tags are 0. The address may hold any value; the pipeline keeps advancing every cycle (no stall).
- Back-to-back pixels: one result per cycle, full throughput.
- Reset mid-frame: in-flight tags drop immediately; pix_out_valid=0 until new pixels traverse the pipeline.

Optional Feature:
- Macro: FRUIT_SPRITE_OVERLAP_EN.
- Defined:
  - Adds output overlap_flags [NUM_SPRITES-1:0], a sticky per-sprite flag.
  - Bit i sets when sprite i covers a valid pixel that at least one other enabled sprite also covers. Used for blade/fruit collision logic.
  - All bits clear on frame_start; a same-cycle set wins over clear.
  - Reset value 0.
- Undefined: port absent; no overlap logic synthesised.

Test Plan:
- Reset, then frame_start with sprite0 at (100,200), en=4'b0001; drive x=100,y=200,pix_valid=1 -> 1 cycle later rom_addr=0, rom_sel=0; at 3 cycles pix_out_valid=1, pix_hit=1 if rom_data!=12'h0F0.
- Same setup, x=149,y=249 -> rom_addr=2499. x=150,y=200 -> pix_hit=0, pix_out=0.
- Sprites 1 and 2 both at (300,100), en=4'b0110; pixel (310,105) -> rom_sel=1, rom_addr=260. Overlap build: overlap_flags=4'b0110 by end of frame; next frame_start clears to 0.
- Sprite0 at (620,470), pixel (639,479) -> hit with rom_addr=19+50*9=469, no wrap. Pixel (5,2) -> no hit.
- Change sprite_x while no frame_start -> coverage unchanged. Pulse frame_start coincident with a pixel -> that pixel uses old position; the next uses the new one.
- Assert reset_n=0 mid-stream with the pipeline full -> all outputs 0 immediately. After release, no hits until frame_start, even with sprite_en=4'hF.
